// File: rtl/ctrl_decode_pipe.sv
`timescale 1ns/1ps
// ctrl_decode_pipe: registered RV32I main-control decoder with a valid/ready output buffer and load-use interlock.
// Define CTRL_DECODE_MEXT_EN to accept R-type funct7=0000001 as an M-extension op (raises o_MulDiv).
module ctrl_decode_pipe #(
  parameter int DEPTH       = 2,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_Instr,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic        i_Flush,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [1:0]  o_Ctrl_Jump,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic [1:0]  o_RegSrc,
  output logic [2:0]  o_ALUOp,
  output logic        o_ALUSrc1,
  output logic        o_ALUSrc2,
  output logic        o_RegWrite,
  output logic        o_CSR_en,
  output logic        o_Illegal,
  output logic        o_MulDiv,
  output logic [4:0]  o_Rd,
  output logic [4:0]  o_Rs1,
  output logic [4:0]  o_Rs2
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0] jump;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_src;
    logic [2:0] alu_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_write;
    logic       csr_en;
    logic       illegal;
    logic       muldiv;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } entry_t;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       unused_funct3;

  logic       legal;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_load;
  entry_t     dec;

  assign opcode        = i_Instr[6:0];
  assign funct7        = i_Instr[31:25];
  assign rd            = i_Instr[11:7];
  assign rs1           = i_Instr[19:15];
  assign rs2           = i_Instr[24:20];
  assign unused_funct3 = ^i_Instr[14:12];

  always_comb begin
    dec      = '0;
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_load  = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 3'b010;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        if (funct7 == 7'b0000001) begin
`ifdef CTRL_DECODE_MEXT_EN
          dec.muldiv = 1'b1;
`else
          legal = 1'b0;
`endif
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          legal = 1'b0;
        end
      end
      OP_I: begin
        dec.alu_src2  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 3'b011;
        uses_rs1      = 1'b1;
      end
      OP_LOAD: begin
        dec.mem_read  = 1'b1;
        dec.reg_src   = 2'b01;
        dec.alu_src2  = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b1;
        is_load       = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src2  = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        dec.jump   = 2'b01;
        dec.alu_op = 3'b001;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_LUI: begin
        dec.alu_src2  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 3'b100;
      end
      OP_AUIPC: begin
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 3'b101;
      end
      OP_JAL: begin
        dec.jump      = 2'b10;
        dec.reg_src   = 2'b10;
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.jump      = 2'b11;
        dec.reg_src   = 2'b10;
        dec.alu_src2  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 3'b011;
        uses_rs1      = 1'b1;
      end
      OP_SYSTEM: begin
        dec.reg_src   = 2'b11;
        dec.reg_write = 1'b1;
        dec.csr_en    = 1'b1;
      end
      OP_FENCE: ;
      default: legal = 1'b0;
    endcase
    if (i_Instr[1:0] != 2'b11) begin
      legal = 1'b0;
    end
    // Illegal words still flow down the pipe, but must not drive any control or hazard.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      is_load     = 1'b0;
    end
    dec.rd  = rd;
    dec.rs1 = rs1;
    dec.rs2 = rs2;
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ld_pend;
  logic [4:0]    ld_rd;
  entry_t        mem [DEPTH];
  entry_t        head_raw;
  entry_t        head;

  logic full;
  logic hazard;
  logic ready;
  logic push;
  logic pop;

  assign full   = (count == CW'(DEPTH));
  assign hazard = LOAD_USE_EN && ld_pend && i_Valid &&
                  ((uses_rs1 && rs1 == ld_rd) || (uses_rs2 && rs2 == ld_rd));
  assign ready  = !full && !hazard && !i_Flush;
  assign push   = i_Valid && ready;
  assign pop    = (count != '0) && i_Ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ld_pend <= 1'b0;
      ld_rd   <= '0;
    end else if (i_Flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ld_pend <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The interlock only ever looks one instruction behind the load.
      ld_pend <= push && is_load && (rd != 5'd0);
      if (push && is_load) begin
        ld_rd <= rd;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge i_clk) begin
        if (push && wr_ptr == PW'(gi)) begin
          mem[gi] <= dec;
        end
      end
    end
    if (DEPTH == 1) begin : g_head_one
      assign head_raw = mem[0];
    end else begin : g_head_many
      assign head_raw = mem[rd_ptr];
    end
  endgenerate

  // Stale storage is never visible: an empty buffer presents an all-zero bundle.
  assign head    = (count != '0) ? head_raw : '0;
  assign o_Valid = (count != '0);
  assign o_Ready = ready;

  assign o_Ctrl_Jump = head.jump;
  assign o_MemRead   = head.mem_read;
  assign o_MemWrite  = head.mem_write;
  assign o_RegSrc    = head.reg_src;
  assign o_ALUOp     = head.alu_op;
  assign o_ALUSrc1   = head.alu_src1;
  assign o_ALUSrc2   = head.alu_src2;
  assign o_RegWrite  = head.reg_write;
  assign o_CSR_en    = head.csr_en;
  assign o_Illegal   = head.illegal;
  assign o_MulDiv    = head.muldiv;
  assign o_Rd        = head.rd;
  assign o_Rs1       = head.rs1;
  assign o_Rs2       = head.rs2;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
`timescale 1ns/1ps
// tb_ctrl_decode_pipe: three DUT variants (D2/LU, D1/LU, D2/no-LU) share one random stimulus stream
// and are checked every cycle against a queue-based reference, plus literal directed checks.
module tb_ctrl_decode_pipe;

  localparam int NI = 3;
`ifdef CTRL_DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] jump;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_src;
    logic [2:0] alu_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_write;
    logic       csr_en;
    logic       illegal;
    logic       muldiv;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        dready = 1'b0;
  logic        flush = 1'b0;

  logic        ov  [NI];
  logic        rdy [NI];
  bundle_t     obs [NI];

  int          mcnt  [NI];
  bundle_t     mq    [NI][2];
  bit          mpend [NI];
  logic [4:0]  mprd  [NI];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [1:0] jump, reg_src;
      logic [2:0] aop;
      logic       v, r, mr, mw, a1, a2, rw, csr, ill, md;
      logic [4:0] rd, rs1, rs2;
      ctrl_decode_pipe #(
        .DEPTH       ((gi == 1) ? 1 : 2),
        .LOAD_USE_EN ((gi == 2) ? 1'b0 : 1'b1)
      ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_Instr     (instr),
        .i_Valid     (valid),
        .o_Ready     (r),
        .i_Flush     (flush),
        .o_Valid     (v),
        .i_Ready     (dready),
        .o_Ctrl_Jump (jump),
        .o_MemRead   (mr),
        .o_MemWrite  (mw),
        .o_RegSrc    (reg_src),
        .o_ALUOp     (aop),
        .o_ALUSrc1   (a1),
        .o_ALUSrc2   (a2),
        .o_RegWrite  (rw),
        .o_CSR_en    (csr),
        .o_Illegal   (ill),
        .o_MulDiv    (md),
        .o_Rd        (rd),
        .o_Rs1       (rs1),
        .o_Rs2       (rs2)
      );
      assign ov[gi]  = v;
      assign rdy[gi] = r;
      assign obs[gi] = {jump, mr, mw, reg_src, aop, a1, a2, rw, csr, ill, md, rd, rs1, rs2};
    end
  endgenerate

  function automatic int dep_of(input int k);
    return (k == 1) ? 1 : 2;
  endfunction

  function automatic bit lue_of(input int k);
    return (k != 2);
  endfunction

  // Row layout: jump, memread, memwrite, regsrc, alusrc1, alusrc2, regwrite, aluop, csr_en.
  function automatic bundle_t ref_decode(input logic [31:0] w);
    bundle_t     b;
    logic [12:0] row;
    bit          ok;
    logic [6:0]  f7;
    b   = '0;
    row = '0;
    ok  = 1'b1;
    f7  = w[31:25];
    case (w[6:0])
      7'b0110011: row = 13'b00_0_0_00_0_0_1_010_0;
      7'b0010011: row = 13'b00_0_0_00_0_1_1_011_0;
      7'b0000011: row = 13'b00_1_0_01_0_1_1_000_0;
      7'b0100011: row = 13'b00_0_1_00_0_1_0_000_0;
      7'b1100011: row = 13'b01_0_0_00_0_0_0_001_0;
      7'b0110111: row = 13'b00_0_0_00_0_1_1_100_0;
      7'b0010111: row = 13'b00_0_0_00_1_1_1_101_0;
      7'b1101111: row = 13'b10_0_0_10_0_0_1_000_0;
      7'b1100111: row = 13'b11_0_0_10_0_1_1_011_0;
      7'b1110011: row = 13'b00_0_0_11_0_0_1_000_1;
      7'b0001111: row = 13'b0;
      default:    ok  = 1'b0;
    endcase
    if (w[1:0] != 2'b11) ok = 1'b0;
    if (w[6:0] == 7'b0110011 && !(f7 == 7'd0 || f7 == 7'h20 || (MEXT && f7 == 7'd1))) ok = 1'b0;
    if (ok) begin
      {b.jump, b.mem_read, b.mem_write, b.reg_src, b.alu_src1, b.alu_src2,
       b.reg_write, b.alu_op, b.csr_en} = row;
      b.muldiv = MEXT && (w[6:0] == 7'b0110011) && (f7 == 7'd1);
    end else begin
      b.illegal = 1'b1;
    end
    b.rd  = w[11:7];
    b.rs1 = w[19:15];
    b.rs2 = w[24:20];
    return b;
  endfunction

  // Returns {uses_rs1, uses_rs2}; illegal words use nothing.
  function automatic logic [1:0] ref_uses(input logic [31:0] w);
    bundle_t b;
    logic [1:0] u;
    b = ref_decode(w);
    u = 2'b00;
    if (!b.illegal) begin
      u[1] = w[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
      u[0] = w[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    end
    return u;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mcnt[k]  = 0;
      mpend[k] = 1'b0;
      mprd[k]  = '0;
      mq[k][0] = '0;
      mq[k][1] = '0;
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Checks all DUTs at the negedge, advances the reference, returns at posedge+1.
  task automatic tick();
    bundle_t    eb, nb;
    bit         ev, er, hz, push, pop;
    logic [1:0] u;
    @(negedge clk);
    nb = ref_decode(instr);
    u  = ref_uses(instr);
    for (int k = 0; k < NI; k++) begin
      hz = lue_of(k) && mpend[k] && valid &&
           ((u[1] && instr[19:15] == mprd[k]) || (u[0] && instr[24:20] == mprd[k]));
      ev = (mcnt[k] > 0);
      eb = ev ? mq[k][0] : '0;
      er = (mcnt[k] < dep_of(k)) && !hz && !flush;
      vectors++;
      if (ov[k] !== ev || rdy[k] !== er || obs[k] !== eb) begin
        miscompares++;
        $display("FAIL model_cmp inst%0d t=%0t: got v=%b r=%b b=%h, want v=%b r=%b b=%h",
                 k, $time, ov[k], rdy[k], obs[k], ev, er, eb);
      end
      push = valid && er;
      pop  = ev && dready;
      if (flush) begin
        mcnt[k]  = 0;
        mpend[k] = 1'b0;
      end else begin
        if (pop) begin
          mq[k][0] = mq[k][1];
          mcnt[k]--;
        end
        if (push) begin
          mq[k][mcnt[k]] = nb;
          mcnt[k]++;
        end
        mpend[k] = push && nb.mem_read && (nb.rd != 5'd0);
        if (mpend[k]) mprd[k] = nb.rd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid  = 1'b0;
    dready = 1'b1;
    flush  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic rand_instr();
    logic [31:0] w;
    int          kind;
    w    = $urandom;
    kind = $urandom_range(0, 13);
    case (kind)
      0:  w[6:0] = 7'b0110011;
      1:  w[6:0] = 7'b0010011;
      2:  w[6:0] = 7'b0000011;
      3:  w[6:0] = 7'b0100011;
      4:  w[6:0] = 7'b1100011;
      5:  w[6:0] = 7'b0110111;
      6:  w[6:0] = 7'b0010111;
      7:  w[6:0] = 7'b1101111;
      8:  w[6:0] = 7'b1100111;
      9:  w[6:0] = 7'b1110011;
      10: w[6:0] = 7'b0001111;
      13: w[6:0] = 7'b0000011;
      default: ;
    endcase
    if (kind != 12) begin
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    instr = w;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    lit("rst_valid", 64'(ov[0]), 64'(1'b0));
    lit("rst_bundle", 64'(obs[0]), 64'(0));
    lit("rst_ready", 64'(rdy[0]), 64'(1'b1));
    rst = 1'b0;
    idle(2);

    // add x3,x1,x2
    valid = 1'b1; dready = 1'b1; instr = 32'h002081B3;
    tick();
    valid = 1'b0;
    #1;
    lit("add_head", 64'({ov[0], obs[0].reg_write, obs[0].alu_op, obs[0].rd, obs[0].rs1, obs[0].rs2}),
        64'({1'b1, 1'b1, 3'b010, 5'd3, 5'd1, 5'd2}));
    idle(3);

    // lw x5,0(x1) then add x6,x5,x1
    valid = 1'b1; instr = 32'h0000A283;
    tick();
    instr = 32'h00128333;
    #1;
    lit("lu_stall", 64'(rdy[0]), 64'(1'b0));
    lit("lu_off_nogap", 64'(rdy[2]), 64'(1'b1));
    tick();
    #1;
    lit("lu_accept", 64'(rdy[0]), 64'(1'b1));
    tick();
    idle(3);

    // Fill DEPTH=2 with i_Ready low, third stalls, then drain in order
    dready = 1'b0; valid = 1'b1; instr = 32'h00500093;
    #1; lit("fill1_rdy", 64'(rdy[0]), 64'(1'b1));
    tick();
    instr = 32'h06400113;
    #1; lit("fill2_rdy", 64'(rdy[0]), 64'(1'b1));
    tick();
    instr = 32'h002081B3;
    #1; lit("fill3_stall", 64'(rdy[0]), 64'(1'b0));
    tick();
    dready = 1'b1;
    #1;
    lit("order1", 64'({ov[0], obs[0].rd}), 64'({1'b1, 5'd1}));
    lit("full_rdy", 64'(rdy[0]), 64'(1'b0));
    tick();
    #1; lit("order2", 64'({ov[0], obs[0].rd}), 64'({1'b1, 5'd2}));
    tick();
    valid = 1'b0;
    #1; lit("order3", 64'({ov[0], obs[0].rd}), 64'({1'b1, 5'd3}));
    idle(3);

    // Illegal words
    valid = 1'b1; instr = 32'hFFFFFFFF;
    tick();
    instr = 32'h00000000;
    #1; lit("ill_ffff", 64'({ov[0], obs[0][29:15]}), 64'({1'b1, 15'd2}));
    tick();
    valid = 1'b0;
    #1; lit("ill_zero", 64'({ov[0], obs[0][29:15]}), 64'({1'b1, 15'd2}));
    idle(2);

    // mul x3,x1,x2
    valid = 1'b1; instr = 32'h022081B3;
    tick();
    valid = 1'b0;
    #1; lit("mul", 64'({obs[0].illegal, obs[0].muldiv, obs[0].reg_write}), 64'(MEXT ? 3'b011 : 3'b100));
    idle(3);

    // Full buffer ending in a load, then flush together with a dependent valid instruction
    dready = 1'b0; valid = 1'b1; instr = 32'h00500093;
    tick();
    instr = 32'h0000A283;
    tick();
    instr = 32'h00128333; flush = 1'b1;
    #1; lit("flush_rdy", 64'(rdy[0]), 64'(1'b0));
    tick();
    flush = 1'b0;
    #1;
    lit("flush_empty", 64'(ov[0]), 64'(1'b0));
    lit("flush_ready", 64'(rdy[0]), 64'(1'b1));
    tick();
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        flush = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        lit("midrst_valid", 64'(ov[0]), 64'(1'b0));
        lit("midrst_bundle", 64'(obs[0]), 64'(0));
        lit("midrst_ready", 64'(rdy[0]), 64'(1'b1));
        rst = 1'b0;
      end
      rand_instr();
      valid  = ($urandom_range(0, 3) != 0);
      dready = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
